inputdev: RTL

Memory-mapped input device on the microsystem bridge. It samples a 32-bit raw switch/button bus, synchronises and debounces it, and exposes the stable value to the CPU. It records per-bit change events in sticky flags and raises an interrupt request toward the CPU. It is the read-side counterpart of the output device: the CPU reads it through the bridge using the same two-bit register select and write-enable style.

---
 rtl/io_pkg.sv | 27 ++
 rtl/inputdev_if.sv | 18 +
 rtl/inputdev_debouncer.sv | 73 +++++++
 rtl/inputdev.sv | 72 +++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: register map shared by the microsystem bridge I/O devices.
//   IO_STATE/IO_FLAGS/IO_CTRL/IO_RAW : two-bit register select offsets
//   IO_CTRL_IE_BIT                   : interrupt-enable bit inside CTRL
//   io_word_t                        : bridge data word
//   io_flags_next                    : W1C sticky-flag update, set wins
package io_pkg;

    localparam int unsigned IO_DATA_W = 32;

    localparam logic [1:0] IO_STATE = 2'b00;
    localparam logic [1:0] IO_FLAGS = 2'b01;
    localparam logic [1:0] IO_CTRL  = 2'b10;
    localparam logic [1:0] IO_RAW   = 2'b11;

    localparam int unsigned IO_CTRL_IE_BIT = 0;

    typedef logic [IO_DATA_W-1:0] io_word_t;

    // Clear bits are applied before set bits are ORed in, so an event on the
    // same edge as a W1C write survives.
    function automatic io_word_t io_flags_next(input io_word_t flags,
                                               input io_word_t clr,
                                               input io_word_t set);
        return (flags & ~clr) | set;
    endfunction

endpackage

// File: rtl/inputdev_if.sv
// inputdev_if: bridge-side register port of the input device.
//   weIn : write strobe          addr : register select
//   din  : CPU write data        dout : combinational read data
//   irq  : level interrupt request
// master = bridge/CPU side, slave = device side.
interface inputdev_if;
    import io_pkg::*;

    logic       weIn;
    logic [1:0] addr;
    io_word_t   din;
    io_word_t   dout;
    logic       irq;

    modport master (output weIn, output addr, output din, input dout, input irq);
    modport slave  (input weIn, input addr, input din, output dout, output irq);

endinterface

// File: rtl/inputdev_debouncer.sv
// debouncer: 2-flop synchroniser plus whole-word debounce.
//   clk, reset    : clock, asynchronous active-high reset
//   raw           : asynchronous input levels
//   sync_o        : synchronised (not debounced) sample
//   stable_o      : debounced value
//   stable_next_o : value stable_o takes on the next edge (lets the parent
//                   flag a change on the same edge stable_o moves)
module debouncer #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] stable_o,
    output logic [WIDTH-1:0] stable_next_o
);

    // The edge that loads cand is itself the first matching sample, so the
    // count saturates at DEBOUNCE_CYCLES-2; with DEBOUNCE_CYCLES==1 stable
    // follows sync directly. Total: DEBOUNCE_CYCLES identical samples.
    localparam logic [CNT_W-1:0] CNT_SAT =
        (DEBOUNCE_CYCLES >= 2) ? CNT_W'(DEBOUNCE_CYCLES - 2) : '0;

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] cand_nx;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

    always_comb begin
        cand_nx   = cand;
        cnt_nx    = cnt;
        stable_nx = stable;
        if (sync != cand) begin
            cand_nx = sync;
            cnt_nx  = '0;
            if (DEBOUNCE_CYCLES == 1) begin
                stable_nx = sync;
            end
        end else if (cnt < CNT_SAT) begin
            cnt_nx = cnt + CNT_W'(1);
        end else begin
            stable_nx = cand;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= '0;
            sync   <= '0;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            meta   <= raw;
            sync   <= meta;
            cand   <= cand_nx;
            cnt    <= cnt_nx;
            stable <= stable_nx;
        end
    end

    assign sync_o        = sync;
    assign stable_o      = stable;
    assign stable_next_o = stable_nx;

endmodule

// File: rtl/inputdev.sv
// inputdev: memory-mapped input device on the microsystem bridge.
//   clk, reset : clock, asynchronous active-high reset
//   sw         : raw 32-bit switch/button levels
//   bus        : bridge register port (weIn, addr, din, dout, irq)
// Registers: STATE (debounced, RO), FLAGS (sticky change, W1C),
//            CTRL (bit0 = IE), RAW (synchronised sample, RO).
// irq = IE & |FLAGS.
module inputdev
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] sw,
    inputdev_if.slave   bus
);

    io_word_t sync_w;
    io_word_t stable_w;
    io_word_t stable_nx_w;
    io_word_t flags;
    io_word_t clr;
    logic     ctrl_ie;

    debouncer #(
        .WIDTH          (IO_DATA_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debouncer (
        .clk          (clk),
        .reset        (reset),
        .raw          (sw),
        .sync_o       (sync_w),
        .stable_o     (stable_w),
        .stable_next_o(stable_nx_w)
    );

    always_comb begin
        clr = '0;
        if (bus.weIn && (bus.addr == IO_FLAGS)) begin
            clr = bus.din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags   <= '0;
            ctrl_ie <= 1'b0;
        end else begin
            flags <= io_flags_next(flags, clr, stable_w ^ stable_nx_w);
            if (bus.weIn && (bus.addr == IO_CTRL)) begin
                ctrl_ie <= bus.din[IO_CTRL_IE_BIT];
            end
        end
    end

    always_comb begin
        bus.dout = '0;
        case (bus.addr)
            IO_STATE: bus.dout = stable_w;
            IO_FLAGS: bus.dout = flags;
            IO_CTRL:  bus.dout[IO_CTRL_IE_BIT] = ctrl_ie;
            IO_RAW:   bus.dout = sync_w;
            default:  bus.dout = '0;
        endcase
    end

    assign bus.irq = ctrl_ie & (|flags);

endmodule
